// File: rtl/kpn_seg_display_driver.sv
// KPN sink that renders each accepted token in hex or decimal on NUM_DIGITS
// active-low 7-segment digits, with a mode-prefix glyph, blanking and overflow.
module kpn_seg_display_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode_dec,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [6:0]              prefix_seg,
    output logic                    overflow,
    output logic                    updated
);

    // Enough BCD digits for 2^DATA_WIDTH-1: ceil(DATA_WIDTH*log10(2)) + 1
    localparam int BCD_DIGITS = (DATA_WIDTH * 30103 + 99999) / 100000 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int SEG_W      = 7 * NUM_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       step_reg;
    logic                   dec_reg;
    logic                   blank_reg;
    logic [SEG_W-1:0]       seg_reg;
    logic [SEG_W-1:0]       seg_next;
    logic [6:0]             prefix_reg;
    logic                   overflow_reg;
    logic                   overflow_next;
    logic                   updated_reg;

    logic [DATA_WIDTH+DISP_W-1:0] hex_ext;
    logic [BCD_W+DISP_W-1:0]      bcd_ext;
    logic [3:0]                   digit_val [NUM_DIGITS];

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Zero-extension lets every displayed digit index exist regardless of widths
    assign hex_ext = {{DISP_W{1'b0}}, data_reg};
    assign bcd_ext = {{DISP_W{1'b0}}, bcd_reg};

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = dec_reg ? bcd_ext[4*gi +: 4] : hex_ext[4*gi +: 4];
        end
    endgenerate

    assign overflow_next = dec_reg ? |(bcd_ext >> DISP_W) : |(hex_ext >> DISP_W);

    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        logic lead_zero;
        lead_zero = 1'b1;
        seg_next  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead_zero = lead_zero & (digit_val[k] == 4'd0);
            if (overflow_next) begin
                seg_next[7*k +: 7] = GLYPH_DASH;
            end else if (blank_reg && lead_zero && (k != 0)) begin
                seg_next[7*k +: 7] = GLYPH_BLANK;
            end else begin
                seg_next[7*k +: 7] = glyph(digit_val[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            bcd_reg      <= '0;
            step_reg     <= '0;
            dec_reg      <= 1'b0;
            blank_reg    <= 1'b0;
            seg_reg      <= {NUM_DIGITS{GLYPH_ZERO}};
            prefix_reg   <= GLYPH_BLANK;
            overflow_reg <= 1'b0;
            updated_reg  <= 1'b0;
        end else begin
            updated_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg  <= in_data;
                        dec_reg   <= mode_dec;
                        blank_reg <= blank_lz;
                        bcd_reg   <= '0;
                        step_reg  <= '0;
                        state_reg <= mode_dec ? CONVERT : UPDATE;
                    end
                end
                CONVERT: begin
                    // The BCD top bit (always 0 with this sizing) recirculates into
                    // the vacated data LSB so no register bit is dropped.
                    bcd_reg  <= {bcd_adj[BCD_W-2:0], data_reg[DATA_WIDTH-1]};
                    data_reg <= {data_reg[DATA_WIDTH-2:0], bcd_adj[BCD_W-1]};
                    step_reg <= step_reg + CNT_W'(1);
                    if (step_reg == CNT_W'(DATA_WIDTH - 1)) begin
                        state_reg <= UPDATE;
                    end
                end
                UPDATE: begin
                    seg_reg      <= seg_next;
                    prefix_reg   <= dec_reg ? GLYPH_D : GLYPH_H;
                    overflow_reg <= overflow_next;
                    updated_reg  <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign seg_out    = seg_reg;
    assign prefix_seg = prefix_reg;
    assign overflow   = overflow_reg;
    assign updated    = updated_reg;

endmodule

// File: tb/tb_kpn_seg_display_driver.sv
// Directed bench for kpn_seg_display_driver: a 16-bit/4-digit instance and an
// 8-bit/2-digit instance driven from a vector table plus handshake/reset sequences.
module tb_kpn_seg_display_driver;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110, BL = 7'b1111111, DS = 7'b0111111;
    localparam logic [6:0] GH = 7'b0001001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] a_data = '0;
    logic        a_valid = 1'b0, a_dec = 1'b0, a_blz = 1'b0;
    logic        a_ready, a_ovf, a_upd;
    logic [27:0] a_seg;
    logic [6:0]  a_pre;

    logic [7:0]  b_data = '0;
    logic        b_valid = 1'b0, b_dec = 1'b0, b_blz = 1'b0;
    logic        b_ready, b_ovf, b_upd;
    logic [13:0] b_seg;
    logic [6:0]  b_pre;

    bit          sel = 1'b0;
    logic        cur_rdy, cur_ovf, cur_upd;
    logic [27:0] cur_seg;
    logic [6:0]  cur_pre;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kpn_seg_display_driver #(.DATA_WIDTH(16), .NUM_DIGITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .mode_dec(a_dec), .blank_lz(a_blz), .seg_out(a_seg),
        .prefix_seg(a_pre), .overflow(a_ovf), .updated(a_upd)
    );

    kpn_seg_display_driver #(.DATA_WIDTH(8), .NUM_DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .mode_dec(b_dec), .blank_lz(b_blz), .seg_out(b_seg),
        .prefix_seg(b_pre), .overflow(b_ovf), .updated(b_upd)
    );

    always_comb begin
        cur_rdy = sel ? b_ready : a_ready;
        cur_ovf = sel ? b_ovf : a_ovf;
        cur_upd = sel ? b_upd : a_upd;
        cur_seg = sel ? {14'b0, b_seg} : a_seg;
        cur_pre = sel ? b_pre : a_pre;
    end

    typedef struct {
        bit          dut;
        bit          dec;
        bit          blz;
        logic [15:0] data;
        logic [27:0] seg;
        logic [6:0]  pre;
        bit          ovf;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one token on the selected DUT and return just after the accept edge.
    task automatic send(input logic [15:0] d, input bit dec, input bit blz);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cur_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_accept", {31'b0, cur_rdy}, 32'd1);
        if (!sel) begin
            a_data = d; a_dec = dec; a_blz = blz; a_valid = 1'b1;
        end else begin
            b_data = d[7:0]; b_dec = dec; b_blz = blz; b_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        // Scramble the mode/data inputs: they must be ignored after accept
        a_dec = ~dec; a_blz = ~blz; a_data = '1;
        b_dec = ~dec; b_blz = ~blz; b_data = '1;
    endtask

    task automatic wait_upd(output int lat);
        lat = 0;
        while (!cur_upd && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg_a"}, {4'b0, a_seg}, {4'b0, G0, G0, G0, G0});
        chk({tag, "_pre_a"}, {25'b0, a_pre}, {25'b0, BL});
        chk({tag, "_ovf_a"}, {31'b0, a_ovf}, 32'd0);
        chk({tag, "_upd_a"}, {31'b0, a_upd}, 32'd0);
        chk({tag, "_seg_b"}, {18'b0, b_seg}, {18'b0, G0, G0});
        chk({tag, "_pre_b"}, {25'b0, b_pre}, {25'b0, BL});
    endtask

    initial begin
        int lat;
        int cnt;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'd1234,  {G1, G2, G3, G4}, GD, 1'b0, 17};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'hBEEF,  {GB, GE, GE, GF}, GH, 1'b0, 1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'd12345, {DS, DS, DS, DS}, GD, 1'b1, 17};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'd0,     {BL, BL, BL, G0}, GD, 1'b0, 17};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h00A5,  {BL, BL, GA, G5}, GH, 1'b0, 1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000,  {G0, G0, G0, G0}, GH, 1'b0, 1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'd65535, {DS, DS, DS, DS}, GD, 1'b1, 17};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'd9999,  {G9, G9, G9, G9}, GD, 1'b0, 17};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0100,  {BL, G1, G0, G0}, GH, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'd1000,  {G1, G0, G0, G0}, GD, 1'b0, 17};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'd56,    {G0, G0, G5, G6}, GD, 1'b0, 17};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h7C6D,  {G7, GC, G6, GD}, GH, 1'b0, 1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 16'd255,   {14'b0, DS, DS},  GD, 1'b1, 9};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 16'd99,    {14'b0, G9, G9},  GD, 1'b0, 9};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h003C,  {14'b0, G3, GC},  GH, 1'b0, 1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 16'd7,     {14'b0, BL, G7},  GD, 1'b0, 9};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'd100,   {14'b0, DS, DS},  GD, 1'b1, 9};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 16'h0008,  {14'b0, BL, G8},  GH, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset_a", {31'b0, a_ready}, 32'd1);
        chk("ready_after_reset_b", {31'b0, b_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            sel = vecs[i].dut;
            send(vecs[i].data, vecs[i].dec, vecs[i].blz);
            wait_upd(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_seg", i), {4'b0, cur_seg}, {4'b0, vecs[i].seg});
            chk($sformatf("v%0d_prefix", i), {25'b0, cur_pre}, {25'b0, vecs[i].pre});
            chk($sformatf("v%0d_overflow", i), {31'b0, cur_ovf}, {31'b0, vecs[i].ovf});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_single_pulse", i), {31'b0, cur_upd}, 32'd0);
            chk($sformatf("v%0d_hold", i), {4'b0, cur_seg}, {4'b0, vecs[i].seg});
            $display("txn v%0d dut=%0d dec=%0d blz=%0d data=%0h seg=%07h pre=%02h ovf=%0d lat=%0d",
                     i, vecs[i].dut, vecs[i].dec, vecs[i].blz, vecs[i].data,
                     cur_seg, cur_pre, cur_ovf, lat);
        end

        // Back-to-back decimal tokens with in_valid held high
        sel = 1'b0;
        @(negedge clk);
        a_data = 16'd1111; a_dec = 1'b1; a_blz = 1'b0; a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_data = 16'd2222;
        cnt = 0;
        @(negedge clk);
        while (!a_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("bp_ready_low_cycles", cnt, 32'd17);
        chk("bp_first_seg", {4'b0, a_seg}, {4'b0, G1, G1, G1, G1});
        chk("bp_first_upd", {31'b0, a_upd}, 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("bp_second_accepted", {31'b0, a_ready}, 32'd0);
        chk("bp_seg_held", {4'b0, a_seg}, {4'b0, G1, G1, G1, G1});
        wait_upd(lat);
        chk("bp_second_latency", lat, 32'd17);
        chk("bp_second_seg", {4'b0, a_seg}, {4'b0, G2, G2, G2, G2});
        $display("txn backpressure ready_low=%0d second_lat=%0d seg=%07h", cnt, lat, a_seg);

        // Reset during conversion of 9999 must abort without any update
        @(posedge clk);
        #1;
        send(16'd9999, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midreset_no_pulse", {31'b0, a_upd}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset_ready", {31'b0, a_ready}, 32'd1);
        chk_reset_vals("after_release");
        send(16'd42, 1'b1, 1'b1);
        wait_upd(lat);
        chk("post_reset_latency", lat, 32'd17);
        chk("post_reset_seg", {4'b0, a_seg}, {4'b0, BL, BL, G4, G2});
        chk("post_reset_prefix", {25'b0, a_pre}, {25'b0, GD});
        $display("txn reset_abort then 42 seg=%07h lat=%0d", a_seg, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
